// File: rtl/min_max_scanner_if.sv
// Sample-stream and result bundle for the frame min/max scanner.
interface min_max_scanner_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = 3
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] max_val;
    logic [IDX_W-1:0] max_idx;
    logic [WIDTH-1:0] min_val;
    logic [IDX_W-1:0] min_idx;

    // Source/consumer side: launches frames, feeds samples, reads results
    modport master (
        output start, in_valid, in_data,
        input  in_ready, busy, done, max_val, max_idx, min_val, min_idx
    );

    // Scanner side
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, busy, done, max_val, max_idx, min_val, min_idx
    );
endinterface

// File: rtl/min_max_scanner.sv
// Frame min/max scanner: one shared unsigned comparator is used first
// against the running max, then against the running min, per sample.
module min_max_scanner #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned COUNT = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    min_max_scanner_if.slave  bus
);
    // One extra bit so the counter can reach COUNT == 2**IDX_W
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CMP_MAX,
        CMP_MIN,
        DONE
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] sample, sample_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic             in_ready_q, busy_q, done_q;

    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             cmp_gt, cmp_lt;

    // Shared strict compare unit; operand B picked by the compare state
    always_comb begin
        cmp_a  = sample;
        cmp_b  = (state == CMP_MIN) ? min_q : max_q;
        cmp_gt = (cmp_a > cmp_b);
        cmp_lt = (cmp_a < cmp_b);
    end

    // Next-state and datapath updates
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sample_d  = sample;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        min_d     = min_q;
        min_idx_d = min_idx_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.in_valid && in_ready_q) begin
                    if (cnt == '0) begin
                        // First sample seeds both extremes
                        max_d     = bus.in_data;
                        min_d     = bus.in_data;
                        max_idx_d = '0;
                        min_idx_d = '0;
                        cnt_d     = CNT_W'(1);
                        state_d   = (COUNT == 1) ? DONE : WAIT;
                    end else begin
                        sample_d = bus.in_data;
                        state_d  = CMP_MAX;
                    end
                end
            end
            CMP_MAX: begin
                if (cmp_gt) begin
                    max_d     = sample;
                    max_idx_d = cnt[IDX_W-1:0];
                end
                state_d = CMP_MIN;
            end
            CMP_MIN: begin
                if (cmp_lt) begin
                    min_d     = sample;
                    min_idx_d = cnt[IDX_W-1:0];
                end
                cnt_d   = cnt + CNT_W'(1);
                state_d = (cnt_d == CNT_W'(COUNT)) ? DONE : WAIT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and status registers; status flags decode the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sample     <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            min_q      <= '0;
            min_idx_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sample     <= sample_d;
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            min_q      <= min_d;
            min_idx_q  <= min_idx_d;
            in_ready_q <= (state_d == WAIT);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.max_val  = max_q;
    assign bus.max_idx  = max_idx_q;
    assign bus.min_val  = min_q;
    assign bus.min_idx  = min_idx_q;

endmodule

// File: tb/tb_min_max_scanner.sv
// Randomized bench for min_max_scanner (COUNT=8 and COUNT=1 instances).
module tb_min_max_scanner;

    typedef logic [3:0] frame_t [8];

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    min_max_scanner_if #(.WIDTH(4), .IDX_W(3)) bus8 ();
    min_max_scanner_if #(.WIDTH(4), .IDX_W(3)) bus1 ();

    min_max_scanner #(.WIDTH(4), .COUNT(8), .IDX_W(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    min_max_scanner #(.WIDTH(4), .COUNT(1), .IDX_W(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: extreme values over the frame, index = first occurrence
    function automatic void ref_extrema(input frame_t s, output logic [3:0] mx, output int imx,
                                        output logic [3:0] mn, output int imn);
        mx = s[0];
        mn = s[0];
        for (int i = 1; i < 8; i++) begin
            if (s[i] > mx) mx = s[i];
            if (s[i] < mn) mn = s[i];
        end
        imx = -1;
        imn = -1;
        for (int i = 0; i < 8; i++) begin
            if (imx < 0 && s[i] == mx) imx = i;
            if (imn < 0 && s[i] == mn) imn = i;
        end
    endfunction

    task automatic check_zero8(input string pfx);
        check_eq({pfx, "_busy"},     32'(bus8.busy),     32'd0);
        check_eq({pfx, "_done"},     32'(bus8.done),     32'd0);
        check_eq({pfx, "_in_ready"}, 32'(bus8.in_ready), 32'd0);
        check_eq({pfx, "_max_val"},  32'(bus8.max_val),  32'd0);
        check_eq({pfx, "_max_idx"},  32'(bus8.max_idx),  32'd0);
        check_eq({pfx, "_min_val"},  32'(bus8.min_val),  32'd0);
        check_eq({pfx, "_min_idx"},  32'(bus8.min_idx),  32'd0);
    endtask

    // Call at #1 after a posedge (that cycle is cycle 0); returns at the same phase.
    task automatic run_frame8(input frame_t s, input int max_gap, input bit timing,
                              input bit poke_start, input int abort_after);
        logic [3:0] emax, emin;
        int  eimax, eimin;
        int  c, k, gap;
        bit  xfer, seen;
        ref_extrema(s, emax, eimax, emin, eimin);
        c    = 0;
        k    = 0;
        seen = 1'b0;
        gap  = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        bus8.start    = 1'b1;
        bus8.in_valid = (gap == 0);
        bus8.in_data  = s[0];
        while (!seen && c < 300) begin
            @(negedge clk);
            if (timing) begin
                check_eq("t_busy",     32'(bus8.busy),     32'(c >= 1 && c <= 23));
                check_eq("t_done",     32'(bus8.done),     32'(c == 23));
                check_eq("t_in_ready", 32'(bus8.in_ready),
                         32'(c == 1 || (c >= 2 && c <= 20 && (c - 2) % 3 == 0)));
            end
            if (bus8.done) begin
                seen = 1'b1;
                check_eq("max_val", 32'(bus8.max_val), 32'(emax));
                check_eq("max_idx", 32'(bus8.max_idx), 32'(eimax));
                check_eq("min_val", 32'(bus8.min_val), 32'(emin));
                check_eq("min_idx", 32'(bus8.min_idx), 32'(eimin));
            end else begin
                xfer = bus8.in_valid && bus8.in_ready;
                @(posedge clk);
                #1;
                c++;
                if (xfer) k++;
                if (abort_after > 0 && k == abort_after) begin
                    bus8.start    = 1'b0;
                    bus8.in_valid = 1'b0;
                    #2 rst = 1'b1;
                    #1 check_zero8("abort");
                    @(negedge clk);
                    check_eq("abort_busy_held", 32'(bus8.busy), 32'd0);
                    rst = 1'b0;
                    @(posedge clk);
                    #1;
                    return;
                end
                bus8.start = poke_start ? 1'($urandom_range(1, 0)) : 1'b0;
                if (xfer && max_gap > 0) gap = int'($urandom_range(max_gap, 0));
                if (gap > 0) begin
                    bus8.in_valid = 1'b0;
                    gap--;
                end else begin
                    bus8.in_valid = (k < 8);
                end
                bus8.in_data = (k < 8) ? s[k] : 4'($urandom);
            end
        end
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus8.start    = 1'b0;
        bus8.in_valid = 1'b0;
        // Results must hold through IDLE while the source toggles freely
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("idle_busy",    32'(bus8.busy),    32'd0);
            check_eq("hold_max_val", 32'(bus8.max_val), 32'(emax));
            check_eq("hold_min_idx", 32'(bus8.min_idx), 32'(eimin));
            bus8.in_valid = 1'($urandom_range(1, 0));
            bus8.in_data  = 4'($urandom);
        end
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Single-sample frame on the COUNT=1 instance; same calling phase as run_frame8.
    task automatic run_frame1(input logic [3:0] v);
        bus1.start    = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.in_data  = v;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("c1_busy",     32'(bus1.busy),     32'(c >= 1 && c <= 2));
            check_eq("c1_done",     32'(bus1.done),     32'(c == 2));
            check_eq("c1_in_ready", 32'(bus1.in_ready), 32'(c == 1));
            if (c >= 2) begin
                check_eq("c1_max_val", 32'(bus1.max_val), 32'(v));
                check_eq("c1_max_idx", 32'(bus1.max_idx), 32'd0);
                check_eq("c1_min_val", 32'(bus1.min_val), 32'(v));
                check_eq("c1_min_idx", 32'(bus1.min_idx), 32'd0);
            end
            @(posedge clk);
            #1;
            bus1.start = 1'b0;
            if (c >= 1) begin
                bus1.in_valid = 1'b0;
                bus1.in_data  = 4'($urandom);
            end
        end
    endtask

    initial begin
        frame_t f;
        rst           = 1'b1;
        bus8.start    = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.in_data  = '0;
        bus1.start    = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero8("reset");
        check_eq("reset_c1_busy", 32'(bus1.busy), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("no_start_busy", 32'(bus8.busy), 32'd0);
        end
        @(posedge clk);
        #1;

        // Basic frame with exact cycle timing
        f = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd0, 4'd15, 4'd7, 4'd1};
        run_frame8(f, 0, 1'b1, 1'b0, 0);

        // Asynchronous reset between edges clears results immediately
        #3 rst = 1'b1;
        #1 check_zero8("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ties: earliest index wins
        f = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        run_frame8(f, 0, 1'b0, 1'b0, 0);
        f = '{4'd2, 4'd9, 4'd9, 4'd2, 4'd5, 4'd9, 4'd2, 4'd3};
        run_frame8(f, 0, 1'b0, 1'b0, 0);

        // Basic frame with handshake gaps and start pulses while busy
        f = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd0, 4'd15, 4'd7, 4'd1};
        run_frame8(f, 5, 1'b0, 1'b1, 0);

        // Extremes landing on the last index
        f = '{4'd5, 4'd3, 4'd8, 4'd2, 4'd7, 4'd6, 4'd4, 4'd15};
        run_frame8(f, 2, 1'b0, 1'b0, 0);
        f = '{4'd5, 4'd3, 4'd8, 4'd2, 4'd7, 4'd6, 4'd4, 4'd0};
        run_frame8(f, 2, 1'b0, 1'b0, 0);

        // Random frames
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) f[i] = 4'($urandom);
            run_frame8(f, int'($urandom_range(3, 0)), 1'b0, 1'($urandom_range(1, 0)), 0);
        end

        // Reset after 4 accepted samples, then a fresh descending frame
        f = '{4'd7, 4'd3, 4'd9, 4'd12, 4'd1, 4'd6, 4'd2, 4'd8};
        run_frame8(f, 0, 1'b0, 1'b0, 4);
        f = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
        run_frame8(f, 0, 1'b1, 1'b0, 0);

        // COUNT=1 instance
        run_frame1(4'd12);
        run_frame1(4'd0);
        run_frame1(4'd15);
        run_frame1(4'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
